// File: rtl/l2_tcdm_demux_mo.sv
// l2_tcdm_demux_mo
// ----------------
// Address demultiplexer from one core-side TCDM master port to N_TARGETS
// slave ports, with up to MAX_OUTSTANDING pipelined requests in flight.
// Responses return in issue order: all in-flight requests must belong to
// the same target, so switching target waits for a full drain. Addresses
// that match no region are answered locally with an error response.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   data_req_i / data_gnt_o    core request / grant
//   data_add_i, data_wen_i, data_wdata_i, data_be_i, data_aux_i
//                              core request payload (aux is returned)
//   data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_aux_o
//                              core response (opc=1 means error)
//   tgt_req_o                  one-hot per-target request
//   tgt_add_o, tgt_wen_o, tgt_wdata_o, tgt_be_o
//                              shared target payload (straight from core)
//   tgt_gnt_i, tgt_r_valid_i, tgt_r_opc_i, tgt_r_rdata_i
//                              per-target grant and response
//   START_ADDR_i, END_ADDR_i   per-target region bounds, START <= add < END
module l2_tcdm_demux_mo #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int AUX_WIDTH       = 4,
  parameter int N_TARGETS       = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hBADACCE5)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            data_req_i,
  output logic                            data_gnt_o,
  input  logic [ADDR_WIDTH-1:0]           data_add_i,
  input  logic                            data_wen_i,
  input  logic [DATA_WIDTH-1:0]           data_wdata_i,
  input  logic [BE_WIDTH-1:0]             data_be_i,
  input  logic [AUX_WIDTH-1:0]            data_aux_i,
  output logic                            data_r_valid_o,
  output logic [DATA_WIDTH-1:0]           data_r_rdata_o,
  output logic                            data_r_opc_o,
  output logic [AUX_WIDTH-1:0]            data_r_aux_o,
  output logic [N_TARGETS-1:0]            tgt_req_o,
  output logic [ADDR_WIDTH-1:0]           tgt_add_o,
  output logic                            tgt_wen_o,
  output logic [DATA_WIDTH-1:0]           tgt_wdata_o,
  output logic [BE_WIDTH-1:0]             tgt_be_o,
  input  logic [N_TARGETS-1:0]            tgt_gnt_i,
  input  logic [N_TARGETS-1:0]            tgt_r_valid_i,
  input  logic [N_TARGETS-1:0]            tgt_r_opc_i,
  input  logic [N_TARGETS*DATA_WIDTH-1:0] tgt_r_rdata_i,
  input  logic [N_TARGETS*ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_TARGETS*ADDR_WIDTH-1:0] END_ADDR_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CUR_W = $clog2(N_TARGETS + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CUR_W-1:0] ERR_IDX  = CUR_W'(N_TARGETS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [CNT_W-1:0]     r_cnt;
  logic [CUR_W-1:0]     r_cur;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [AUX_WIDTH-1:0] r_aux_mem [MAX_OUTSTANDING];

  logic [N_TARGETS-1:0]  w_match;
  logic [N_TARGETS-1:0]  w_dest_oh;
  logic [N_TARGETS-1:0]  w_cur_oh;
  logic [CUR_W-1:0]      w_dest;
  logic                  w_dest_err;
  logic                  w_cur_err;
  logic                  w_idle;
  logic                  w_full;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_sel_valid;
  logic                  w_sel_opc;
  logic [DATA_WIDTH-1:0] w_sel_rdata;

  // Region match and one-hot views of the decoded / in-flight target.
  generate
    for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_tgt
      assign w_match[gi] = (data_add_i >= START_ADDR_i[gi*ADDR_WIDTH +: ADDR_WIDTH]) &&
                           (data_add_i <  END_ADDR_i[gi*ADDR_WIDTH +: ADDR_WIDTH]);
      assign w_dest_oh[gi] = (w_dest == CUR_W'(gi));
      assign w_cur_oh[gi]  = (r_cur  == CUR_W'(gi));
    end
  endgenerate

  // Lowest matching index wins when regions overlap.
  always_comb begin
    w_dest = ERR_IDX;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (w_match[i]) w_dest = CUR_W'(i);
    end
  end

  assign w_dest_err = (w_dest == ERR_IDX);
  assign w_cur_err  = (r_cur == ERR_IDX);
  assign w_idle     = (r_cnt == '0);
  assign w_full     = (r_cnt == CNT_MAX);

  // Only issue to the same target as the in-flight ones; anything else
  // waits until the pipeline has drained so responses stay ordered.
  assign w_issue    = data_req_i && !w_full && (w_idle || (w_dest == r_cur));
  assign tgt_req_o  = w_issue ? w_dest_oh : '0;
  assign data_gnt_o = w_issue && (w_dest_err || (|(w_dest_oh & tgt_gnt_i)));

  assign tgt_add_o   = data_add_i;
  assign tgt_wen_o   = data_wen_i;
  assign tgt_wdata_o = data_wdata_i;
  assign tgt_be_o    = data_be_i;

  // Response mux from the current target.
  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < N_TARGETS; i++) begin
      w_sel_rdata = w_sel_rdata |
                    ({DATA_WIDTH{w_cur_oh[i]}} & tgt_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end
  assign w_sel_valid = |(w_cur_oh & tgt_r_valid_i);
  assign w_sel_opc   = |(w_cur_oh & tgt_r_opc_i);

  // While idle every response input is ignored and outputs read zero; the
  // local error target answers one request per cycle.
  assign data_r_valid_o = !w_idle && (w_cur_err || w_sel_valid);
  assign data_r_rdata_o = w_idle ? '0 : (w_cur_err ? ERR_RDATA : w_sel_rdata);
  assign data_r_opc_o   = !w_idle && (w_cur_err || w_sel_opc);
  assign data_r_aux_o   = w_idle ? '0 : r_aux_mem[r_rd_ptr];

  assign w_push = data_req_i && data_gnt_o;
  assign w_pop  = data_r_valid_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_cur    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) begin
        r_cur    <= w_dest;
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Aux storage needs no reset: it is only read while r_cnt > 0.
  always_ff @(posedge clk) begin
    if (w_push) r_aux_mem[r_wr_ptr] <= data_aux_i;
  end

endmodule

// File: tb/tb_l2_tcdm_demux_mo.sv
// Testbench for l2_tcdm_demux_mo: directed scenarios with hand-computed
// expectations. Address map: target0 [0x0000,0x1000), target1
// [0x1000,0x2000), target2 [0x2000,0x3000).
module tb_l2_tcdm_demux_mo;

  logic        clk;
  logic        rst_n;
  logic        data_req_i;
  logic        data_gnt_o;
  logic [31:0] data_add_i;
  logic        data_wen_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic [3:0]  data_aux_i;
  logic        data_r_valid_o;
  logic [31:0] data_r_rdata_o;
  logic        data_r_opc_o;
  logic [3:0]  data_r_aux_o;
  logic [2:0]  tgt_req_o;
  logic [31:0] tgt_add_o;
  logic        tgt_wen_o;
  logic [31:0] tgt_wdata_o;
  logic [3:0]  tgt_be_o;
  logic [2:0]  tgt_gnt_i;
  logic [2:0]  tgt_r_valid_i;
  logic [2:0]  tgt_r_opc_i;
  logic [95:0] tgt_r_rdata_i;
  logic [95:0] START_ADDR_i;
  logic [95:0] END_ADDR_i;

  logic [31:0] rd   [3];
  logic [31:0] st_a [3];
  logic [31:0] en_a [3];

  int n_total = 0;
  int n_bad   = 0;

  assign tgt_r_rdata_i = {rd[2], rd[1], rd[0]};
  assign START_ADDR_i  = {st_a[2], st_a[1], st_a[0]};
  assign END_ADDR_i    = {en_a[2], en_a[1], en_a[0]};

  l2_tcdm_demux_mo dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_add_i     (data_add_i),
    .data_wen_i     (data_wen_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_aux_i     (data_aux_i),
    .data_r_valid_o (data_r_valid_o),
    .data_r_rdata_o (data_r_rdata_o),
    .data_r_opc_o   (data_r_opc_o),
    .data_r_aux_o   (data_r_aux_o),
    .tgt_req_o      (tgt_req_o),
    .tgt_add_o      (tgt_add_o),
    .tgt_wen_o      (tgt_wen_o),
    .tgt_wdata_o    (tgt_wdata_o),
    .tgt_be_o       (tgt_be_o),
    .tgt_gnt_i      (tgt_gnt_i),
    .tgt_r_valid_i  (tgt_r_valid_i),
    .tgt_r_opc_i    (tgt_r_opc_i),
    .tgt_r_rdata_i  (tgt_r_rdata_i),
    .START_ADDR_i   (START_ADDR_i),
    .END_ADDR_i     (END_ADDR_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per granted request and per delivered response.
  always @(negedge clk) begin
    if (rst_n && data_req_i && data_gnt_o)
      $display("req  t=%0t add=%h aux=%0d tgt_req=%b", $time, data_add_i, data_aux_i, tgt_req_o);
    if (rst_n && data_r_valid_o)
      $display("resp t=%0t rdata=%h opc=%0d aux=%0d", $time, data_r_rdata_o, data_r_opc_o, data_r_aux_o);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    data_req_i    = 1'b0;
    tgt_gnt_i     = 3'b000;
    tgt_r_valid_i = 3'b000;
    tgt_r_opc_i   = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    data_add_i = 32'h0; data_wen_i = 1'b1; data_wdata_i = 32'h0;
    data_be_i = 4'hF; data_aux_i = 4'h0;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 32'hDEAD0000 + i; st_a[i] = 32'h1000 * i; en_a[i] = 32'h1000 * (i + 1);
    end
    #2;
    n_total++;
    if ({tgt_req_o, data_gnt_o, data_r_valid_o, data_r_opc_o} !== 6'b0 ||
        data_r_rdata_o !== 32'h0 || data_r_aux_o !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b gnt=%b rv=%b opc=%b rdata=%h aux=%h, want all 0",
               tgt_req_o, data_gnt_o, data_r_valid_o, data_r_opc_o, data_r_rdata_o, data_r_aux_o);
    end
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    cyc();
    data_req_i = 1'b1; data_add_i = 32'h1004; data_aux_i = 4'd5;
    data_wdata_i = 32'h12345678; tgt_gnt_i = 3'b010;
    #1;
    n_total++;
    if (data_gnt_o !== 1'b1 || tgt_req_o !== 3'b010) begin
      n_bad++;
      $display("FAIL single_issue: gnt=%b tgt_req=%b, want 1 010", data_gnt_o, tgt_req_o);
    end
    n_total++;
    if (tgt_add_o !== 32'h1004 || tgt_wdata_o !== 32'h12345678 || tgt_wen_o !== 1'b1) begin
      n_bad++;
      $display("FAIL payload: add=%h wdata=%h wen=%b, want 1004 12345678 1", tgt_add_o, tgt_wdata_o, tgt_wen_o);
    end
    cyc();
    idle_inputs();
    #1;
    n_total++;
    if (data_r_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early: r_valid=%b, want 0", data_r_valid_o);
    end
    cyc();
    tgt_r_valid_i = 3'b010; rd[1] = 32'hCAFE0001;
    #1;
    n_total++;
    if (data_r_valid_o !== 1'b1 || data_r_rdata_o !== 32'hCAFE0001 ||
        data_r_aux_o !== 4'd5 || data_r_opc_o !== 1'b0) begin
      n_bad++;
      $display("FAIL single_resp: rv=%b rdata=%h aux=%0d opc=%b, want 1 cafe0001 5 0",
               data_r_valid_o, data_r_rdata_o, data_r_aux_o, data_r_opc_o);
    end
    cyc();
    idle_inputs();
    #1;
    n_total++;
    if (data_r_valid_o !== 1'b0 || data_r_rdata_o !== 32'h0) begin
      n_bad++;
      $display("FAIL single_after: rv=%b rdata=%h, want 0 0", data_r_valid_o, data_r_rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      data_req_i = 1'b1; data_add_i = 32'h0010; data_aux_i = 4'(i); tgt_gnt_i = 3'b001;
      #1;
      n_total++;
      if (data_gnt_o !== 1'b1 || tgt_req_o !== 3'b001) begin
        n_bad++;
        $display("FAIL b2b_grant%0d: gnt=%b tgt_req=%b, want 1 001", i, data_gnt_o, tgt_req_o);
      end
    end
    cyc();
    data_aux_i = 4'd5;
    #1;
    n_total++;
    if (data_gnt_o !== 1'b0 || tgt_req_o !== 3'b000) begin
      n_bad++;
      $display("FAIL b2b_full: gnt=%b tgt_req=%b, want 0 000", data_gnt_o, tgt_req_o);
    end
    cyc();
    tgt_r_valid_i = 3'b001; rd[0] = 32'h00000A01;
    #1;
    n_total++;
    if (data_r_valid_o !== 1'b1 || data_r_aux_o !== 4'd1 || data_gnt_o !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first_resp: rv=%b aux=%0d gnt=%b, want 1 1 0", data_r_valid_o, data_r_aux_o, data_gnt_o);
    end
    cyc();
    tgt_r_valid_i = 3'b000;
    #1;
    n_total++;
    if (data_gnt_o !== 1'b1 || tgt_req_o !== 3'b001) begin
      n_bad++;
      $display("FAIL b2b_regrant: gnt=%b tgt_req=%b, want 1 001", data_gnt_o, tgt_req_o);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      data_req_i = 1'b0; tgt_gnt_i = 3'b000; tgt_r_valid_i = 3'b001;
      #1;
      n_total++;
      if (data_r_valid_o !== 1'b1 || data_r_aux_o !== 4'(k + 2)) begin
        n_bad++;
        $display("FAIL b2b_order%0d: rv=%b aux=%0d, want 1 %0d", k, data_r_valid_o, data_r_aux_o, k + 2);
      end
    end
    cyc();
    idle_inputs();
    #1;
    n_total++;
    if (data_r_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drained: rv=%b, want 0", data_r_valid_o);
    end
  endtask

  task automatic test_target_switch();
    for (int i = 1; i <= 2; i++) begin
      cyc();
      data_req_i = 1'b1; data_add_i = 32'h0100; data_aux_i = 4'(i); tgt_gnt_i = 3'b001;
      #1;
    end
    cyc();
    data_add_i = 32'h2000; data_aux_i = 4'd7; tgt_gnt_i = 3'b111;
    #1;
    n_total++;
    if (data_gnt_o !== 1'b0 || tgt_req_o !== 3'b000) begin
      n_bad++;
      $display("FAIL switch_block: gnt=%b tgt_req=%b, want 0 000", data_gnt_o, tgt_req_o);
    end
    for (int k = 1; k <= 2; k++) begin
      cyc();
      tgt_r_valid_i = 3'b001;
      #1;
      n_total++;
      if (data_gnt_o !== 1'b0 || tgt_req_o !== 3'b000 || data_r_valid_o !== 1'b1 || data_r_aux_o !== 4'(k)) begin
        n_bad++;
        $display("FAIL switch_drain%0d: gnt=%b tgt_req=%b rv=%b aux=%0d, want 0 000 1 %0d",
                 k, data_gnt_o, tgt_req_o, data_r_valid_o, data_r_aux_o, k);
      end
    end
    cyc();
    tgt_r_valid_i = 3'b000;
    #1;
    n_total++;
    if (data_gnt_o !== 1'b1 || tgt_req_o !== 3'b100) begin
      n_bad++;
      $display("FAIL switch_grant: gnt=%b tgt_req=%b, want 1 100", data_gnt_o, tgt_req_o);
    end
    cyc();
    idle_inputs();
    tgt_r_valid_i = 3'b100; rd[2] = 32'h22220002;
    #1;
    n_total++;
    if (data_r_valid_o !== 1'b1 || data_r_aux_o !== 4'd7 || data_r_rdata_o !== 32'h22220002) begin
      n_bad++;
      $display("FAIL switch_resp: rv=%b aux=%0d rdata=%h, want 1 7 22220002",
               data_r_valid_o, data_r_aux_o, data_r_rdata_o);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_unmapped();
    cyc();
    data_req_i = 1'b1; data_add_i = 32'h0200; data_aux_i = 4'd3; tgt_gnt_i = 3'b001;
    #1;
    cyc();
    data_add_i = 32'hFFFF0000; data_aux_i = 4'd9;
    #1;
    n_total++;
    if (data_gnt_o !== 1'b0 || tgt_req_o !== 3'b000) begin
      n_bad++;
      $display("FAIL err_hold: gnt=%b tgt_req=%b, want 0 000", data_gnt_o, tgt_req_o);
    end
    cyc();
    tgt_r_valid_i = 3'b001;
    #1;
    n_total++;
    if (data_gnt_o !== 1'b0 || data_r_aux_o !== 4'd3 || data_r_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL err_drain: gnt=%b rv=%b aux=%0d, want 0 1 3", data_gnt_o, data_r_valid_o, data_r_aux_o);
    end
    cyc();
    tgt_r_valid_i = 3'b000;
    #1;
    n_total++;
    if (data_gnt_o !== 1'b1 || tgt_req_o !== 3'b000 || data_r_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL err_grant: gnt=%b tgt_req=%b rv=%b, want 1 000 0", data_gnt_o, tgt_req_o, data_r_valid_o);
    end
    cyc();
    data_aux_i = 4'd10;
    #1;
    n_total++;
    if (data_gnt_o !== 1'b1 || data_r_valid_o !== 1'b1 || data_r_opc_o !== 1'b1 ||
        data_r_rdata_o !== 32'hBADACCE5 || data_r_aux_o !== 4'd9) begin
      n_bad++;
      $display("FAIL err_resp1: gnt=%b rv=%b opc=%b rdata=%h aux=%0d, want 1 1 1 badacce5 9",
               data_gnt_o, data_r_valid_o, data_r_opc_o, data_r_rdata_o, data_r_aux_o);
    end
    cyc();
    idle_inputs();
    #1;
    n_total++;
    if (data_r_valid_o !== 1'b1 || data_r_opc_o !== 1'b1 || data_r_aux_o !== 4'd10) begin
      n_bad++;
      $display("FAIL err_resp2: rv=%b opc=%b aux=%0d, want 1 1 10", data_r_valid_o, data_r_opc_o, data_r_aux_o);
    end
    cyc();
    #1;
    n_total++;
    if (data_r_valid_o !== 1'b0 || data_r_opc_o !== 1'b0) begin
      n_bad++;
      $display("FAIL err_done: rv=%b opc=%b, want 0 0", data_r_valid_o, data_r_opc_o);
    end
  endtask

  task automatic test_overlap();
    cyc();
    en_a[0] = 32'h2000;
    data_req_i = 1'b1; data_add_i = 32'h1000; tgt_gnt_i = 3'b000;
    #1;
    n_total++;
    if (tgt_req_o !== 3'b001 || data_gnt_o !== 1'b0) begin
      n_bad++;
      $display("FAIL overlap: tgt_req=%b gnt=%b, want 001 0", tgt_req_o, data_gnt_o);
    end
    cyc();
    idle_inputs();
    en_a[0] = 32'h1000;
  endtask

  task automatic test_spurious_reset();
    for (int i = 1; i <= 3; i++) begin
      cyc();
      data_req_i = 1'b1; data_add_i = 32'h0300; data_aux_i = 4'(i); tgt_gnt_i = 3'b001;
      #1;
    end
    cyc();
    idle_inputs();
    tgt_r_valid_i = 3'b100; rd[2] = 32'h5A5A5A5A;
    #1;
    n_total++;
    if (data_r_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL spurious: rv=%b, want 0", data_r_valid_o);
    end
    cyc();
    tgt_r_valid_i = 3'b000;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({tgt_req_o, data_gnt_o, data_r_valid_o, data_r_opc_o} !== 6'b0 ||
        data_r_rdata_o !== 32'h0 || data_r_aux_o !== 4'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs: req=%b gnt=%b rv=%b opc=%b rdata=%h aux=%h, want all 0",
               tgt_req_o, data_gnt_o, data_r_valid_o, data_r_opc_o, data_r_rdata_o, data_r_aux_o);
    end
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      tgt_r_valid_i = 3'b001; rd[0] = 32'h0B0B0B0B;
      #1;
      n_total++;
      if (data_r_valid_o !== 1'b0 || data_r_rdata_o !== 32'h0 || data_r_aux_o !== 4'h0) begin
        n_bad++;
        $display("FAIL late_resp%0d: rv=%b rdata=%h aux=%h, want 0 0 0", k, data_r_valid_o, data_r_rdata_o, data_r_aux_o);
      end
    end
    // Count cleared: a request to a different target must issue at once.
    cyc();
    tgt_r_valid_i = 3'b000;
    data_req_i = 1'b1; data_add_i = 32'h2010; data_aux_i = 4'd12; tgt_gnt_i = 3'b100;
    #1;
    n_total++;
    if (data_gnt_o !== 1'b1 || tgt_req_o !== 3'b100) begin
      n_bad++;
      $display("FAIL post_reset_grant: gnt=%b tgt_req=%b, want 1 100", data_gnt_o, tgt_req_o);
    end
    cyc();
    idle_inputs();
    tgt_r_valid_i = 3'b100;
    #1;
    n_total++;
    if (data_r_valid_o !== 1'b1 || data_r_aux_o !== 4'd12) begin
      n_bad++;
      $display("FAIL post_reset_resp: rv=%b aux=%0d, want 1 12", data_r_valid_o, data_r_aux_o);
    end
    cyc();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_target_switch();
    test_unmapped();
    test_overlap();
    test_spurious_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
